// File: rtl/hardisc_ahb_arbiter_pkg.sv
// Shared AHB-Lite types for the hardisc master arbiter: transfer encodings and address-phase record.
// Pure declarations; no timing or flow-control behaviour of its own.
package p_hardisc;
    localparam int HPARITY_MAX_W = 6;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    typedef struct packed {
        logic [31:0]              addr;
        logic                     write;
        logic [2:0]               size;
        logic [HPARITY_MAX_W-1:0] parity;
    } ahb_addr_ph_t;

    typedef enum logic [1:0] {
        PB_IDLE = 2'b00,
        PB_PEND = 2'b01,
        PB_DATA = 2'b10
    } pb_state_t;
endpackage

// File: rtl/hardisc_ahb_arbiter_pend_buf.sv
// One master's capture register and IDLE/PEND/DATA FSM; request is seen combinationally, capture on the edge.
// Backpressure: hready low while a request is parked, follows slave hready while in the data phase.
module hardisc_ahb_pend_buf
    import p_hardisc::*;
(
    input  logic         s_clk_i,
    input  logic         s_reset_i,
    input  logic [1:0]   s_htrans_i,
    input  ahb_addr_ph_t s_addr_ph_i,
    input  logic         s_hready_i,
    input  logic         s_hresp_i,
    input  logic         s_gnt_i,
    output logic         s_req_o,
    output logic         s_pend_o,
    output ahb_addr_ph_t s_buf_o,
    output logic         s_hready_o,
    output logic         s_hresp_o
);
    pb_state_t    state_q, state_d;
    ahb_addr_ph_t buf_q, buf_d;
    logic         owner;

    always_comb begin
        owner      = (state_q == PB_DATA);
        s_pend_o   = (state_q == PB_PEND);
        s_hready_o = owner ? s_hready_i : !s_pend_o;
        s_hresp_o  = owner && s_hresp_i;
        // A transfer offered on the error-completing edge is dropped, not parked.
        s_req_o    = s_hready_o && (s_htrans_i inside {HTRANS_NONSEQ, HTRANS_SEQ})
                     && !(owner && s_hresp_i);
        s_buf_o    = buf_q;
        state_d    = state_q;
        buf_d      = buf_q;
        if (s_gnt_i) begin
            state_d = PB_DATA;
        end else if (s_req_o) begin
            state_d = PB_PEND;
            buf_d   = s_addr_ph_i;
        end else if (owner && s_hready_i) begin
            state_d = PB_IDLE;
        end
    end

    always_ff @(posedge s_clk_i or posedge s_reset_i) begin
        if (s_reset_i) begin
            state_q <= PB_IDLE;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
        end
    end
endmodule

// File: rtl/hardisc_ahb_arbiter.sv
// AHB-Lite N:1 arbiter, zero-latency bypass when no request is parked; HARDISC_ARB_RR_EN selects round-robin.
// Parked requests always win over fresh ones; losers stall via their own hready until issued.
module hardisc_ahb_arbiter
    import p_hardisc::*;
#(
    parameter int MASTERS  = 2,
    parameter int PARITY_W = 6
) (
    input  logic                s_clk_i,
    input  logic                s_reset_i,
    input  logic [31:0]         s_m_haddr_i      [MASTERS],
    input  logic [1:0]          s_m_htrans_i     [MASTERS],
    input  logic                s_m_hwrite_i     [MASTERS],
    input  logic [2:0]          s_m_hsize_i      [MASTERS],
    input  logic [PARITY_W-1:0] s_m_hparity_i    [MASTERS],
    input  logic [31:0]         s_m_hwdata_i     [MASTERS],
    input  logic [6:0]          s_m_hwchecksum_i [MASTERS],
    output logic [31:0]         s_m_hrdata_o     [MASTERS],
    output logic [6:0]          s_m_hrchecksum_o [MASTERS],
    output logic                s_m_hready_o     [MASTERS],
    output logic                s_m_hresp_o      [MASTERS],
    output logic [31:0]         s_haddr_o,
    output logic [1:0]          s_htrans_o,
    output logic                s_hwrite_o,
    output logic [2:0]          s_hsize_o,
    output logic [PARITY_W-1:0] s_hparity_o,
    output logic [31:0]         s_hwdata_o,
    output logic [6:0]          s_hwchecksum_o,
    input  logic [31:0]         s_hrdata_i,
    input  logic [6:0]          s_hrchecksum_i,
    input  logic                s_hready_i,
    input  logic                s_hresp_i,
    output logic [MASTERS-1:0]  s_grant_o
);
    localparam int IDX_W = $clog2(MASTERS);

    logic [MASTERS-1:0] req, pend, cand, grant;
    ahb_addr_ph_t       in_ph [MASTERS];
    ahb_addr_ph_t       buf_ph[MASTERS];
    ahb_addr_ph_t       ph;
    logic [IDX_W-1:0]   gnt_idx, owner_idx_q, owner_idx_d;
    logic               gnt_vld, owner_vld_q, owner_vld_d;

    for (genvar m = 0; m < MASTERS; m++) begin : g_m
        assign in_ph[m] = '{addr:   s_m_haddr_i[m],
                            write:  s_m_hwrite_i[m],
                            size:   s_m_hsize_i[m],
                            parity: HPARITY_MAX_W'(s_m_hparity_i[m])};

        hardisc_ahb_pend_buf u_pend_buf (
            .s_clk_i     (s_clk_i),
            .s_reset_i   (s_reset_i),
            .s_htrans_i  (s_m_htrans_i[m]),
            .s_addr_ph_i (in_ph[m]),
            .s_hready_i  (s_hready_i),
            .s_hresp_i   (s_hresp_i),
            .s_gnt_i     (grant[m]),
            .s_req_o     (req[m]),
            .s_pend_o    (pend[m]),
            .s_buf_o     (buf_ph[m]),
            .s_hready_o  (s_m_hready_o[m]),
            .s_hresp_o   (s_m_hresp_o[m])
        );

        assign s_m_hrdata_o[m]     = (owner_vld_q && owner_idx_q == IDX_W'(m)) ? s_hrdata_i : '0;
        assign s_m_hrchecksum_o[m] = (owner_vld_q && owner_idx_q == IDX_W'(m)) ? s_hrchecksum_i : '0;
    end

`ifdef HARDISC_ARB_RR_EN
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    int               j;
`endif

    always_comb begin
        cand = (|pend) ? pend : req;
        if (!s_hready_i || s_reset_i) begin
            cand = '0;
        end
        gnt_vld = 1'b0;
        gnt_idx = '0;
        grant   = '0;
`ifdef HARDISC_ARB_RR_EN
        j = 0;
        for (int k = 0; k < MASTERS; k++) begin
            j = (int'(rr_ptr_q) + k) % MASTERS;
            if (!gnt_vld && cand[j]) begin
                gnt_vld = 1'b1;
                gnt_idx = IDX_W'(j);
            end
        end
`else
        // Scan downward so the lowest requesting index is the last writer.
        for (int k = MASTERS - 1; k >= 0; k--) begin
            if (cand[k]) begin
                gnt_vld = 1'b1;
                gnt_idx = IDX_W'(k);
            end
        end
`endif
        if (gnt_vld) begin
            grant[gnt_idx] = 1'b1;
        end
        ph = pend[gnt_idx] ? buf_ph[gnt_idx] : in_ph[gnt_idx];
        if (!gnt_vld) begin
            ph = '0;
        end
        owner_vld_d = owner_vld_q;
        owner_idx_d = owner_idx_q;
        if (s_hready_i) begin
            owner_vld_d = gnt_vld;
            owner_idx_d = gnt_idx;
        end
    end

    assign s_grant_o      = grant;
    assign s_htrans_o     = gnt_vld ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign s_haddr_o      = ph.addr;
    assign s_hwrite_o     = ph.write;
    assign s_hsize_o      = ph.size;
    assign s_hparity_o    = ph.parity[PARITY_W-1:0];
    assign s_hwdata_o     = owner_vld_q ? s_m_hwdata_i[owner_idx_q] : '0;
    assign s_hwchecksum_o = owner_vld_q ? s_m_hwchecksum_i[owner_idx_q] : '0;

    always_ff @(posedge s_clk_i or posedge s_reset_i) begin
        if (s_reset_i) begin
            owner_vld_q <= 1'b0;
            owner_idx_q <= '0;
        end else begin
            owner_vld_q <= owner_vld_d;
            owner_idx_q <= owner_idx_d;
        end
    end

`ifdef HARDISC_ARB_RR_EN
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (gnt_vld) begin
            rr_ptr_d = (gnt_idx == IDX_W'(MASTERS - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge s_clk_i or posedge s_reset_i) begin
        if (s_reset_i) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif
endmodule

// File: tb/tb_hardisc_ahb_arbiter.sv
// Directed table-driven bench for hardisc_ahb_arbiter (default fixed-priority build, two masters).
module tb_hardisc_ahb_arbiter;
    import p_hardisc::*;

    localparam int M  = 2;
    localparam int PW = 6;
    localparam logic [1:0]  N  = 2'b10;
    localparam logic [1:0]  I  = 2'b00;
    localparam logic [31:0] W0 = 32'hDEAD_BEEF;
    localparam logic [31:0] W1 = 32'h1111_2222;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   m_haddr [M];
    logic [1:0]    m_htrans[M];
    logic          m_hwrite[M];
    logic [2:0]    m_hsize [M];
    logic [PW-1:0] m_hpar  [M];
    logic [31:0]   m_hwdata[M];
    logic [6:0]    m_hwchk [M];
    logic [31:0]   m_hrdata[M];
    logic [6:0]    m_hrchk [M];
    logic          m_hready[M];
    logic          m_hresp [M];
    logic [31:0]   s_haddr, s_hwdata, s_hrdata;
    logic [1:0]    s_htrans;
    logic          s_hwrite, s_hready, s_hresp;
    logic [2:0]    s_hsize;
    logic [PW-1:0] s_hpar;
    logic [6:0]    s_hwchk, s_hrchk;
    logic [M-1:0]  s_grant;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hardisc_ahb_arbiter #(.MASTERS(M), .PARITY_W(PW)) dut (
        .s_clk_i(clk), .s_reset_i(rst),
        .s_m_haddr_i(m_haddr), .s_m_htrans_i(m_htrans), .s_m_hwrite_i(m_hwrite),
        .s_m_hsize_i(m_hsize), .s_m_hparity_i(m_hpar), .s_m_hwdata_i(m_hwdata),
        .s_m_hwchecksum_i(m_hwchk), .s_m_hrdata_o(m_hrdata), .s_m_hrchecksum_o(m_hrchk),
        .s_m_hready_o(m_hready), .s_m_hresp_o(m_hresp),
        .s_haddr_o(s_haddr), .s_htrans_o(s_htrans), .s_hwrite_o(s_hwrite), .s_hsize_o(s_hsize),
        .s_hparity_o(s_hpar), .s_hwdata_o(s_hwdata), .s_hwchecksum_o(s_hwchk),
        .s_hrdata_i(s_hrdata), .s_hrchecksum_i(s_hrchk), .s_hready_i(s_hready), .s_hresp_i(s_hresp),
        .s_grant_o(s_grant)
    );

    typedef struct {
        logic [1:0] t0; logic [31:0] a0; logic w0;
        logic [1:0] t1; logic [31:0] a1; logic w1;
        logic rdy; logic resp; logic [31:0] rdat;
        logic [1:0] e_trans; logic [31:0] e_addr; logic e_wr; logic [1:0] e_gnt;
        logic [1:0] e_rdy; logic [1:0] e_resp; logic [31:0] e_wdata;
        logic [31:0] e_rd0; logic [31:0] e_rd1;
    } vec_t;

    localparam int NV = 25;
    vec_t vt[NV];

    function automatic vec_t mk(
        logic [1:0] t0, logic [31:0] a0, logic w0, logic [1:0] t1, logic [31:0] a1, logic w1,
        logic rdy, logic resp, logic [31:0] rdat,
        logic [1:0] e_trans, logic [31:0] e_addr, logic e_wr, logic [1:0] e_gnt,
        logic [1:0] e_rdy, logic [1:0] e_resp, logic [31:0] e_wdata,
        logic [31:0] e_rd0, logic [31:0] e_rd1);
        vec_t v;
        v.t0 = t0; v.a0 = a0; v.w0 = w0; v.t1 = t1; v.a1 = a1; v.w1 = w1;
        v.rdy = rdy; v.resp = resp; v.rdat = rdat;
        v.e_trans = e_trans; v.e_addr = e_addr; v.e_wr = e_wr; v.e_gnt = e_gnt;
        v.e_rdy = e_rdy; v.e_resp = e_resp; v.e_wdata = e_wdata; v.e_rd0 = e_rd0; v.e_rd1 = e_rd1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] t0, input logic [31:0] a0, input logic w0,
                         input logic [1:0] t1, input logic [31:0] a1, input logic w1,
                         input logic rdy, input logic resp, input logic [31:0] rdat);
        m_htrans[0] = t0; m_haddr[0] = a0; m_hwrite[0] = w0;
        m_htrans[1] = t1; m_haddr[1] = a1; m_hwrite[1] = w1;
        s_hready = rdy; s_hresp = resp; s_hrdata = rdat;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Single-master read, then fixed-priority collision.
        vt[0]  = mk(I,0,0, N,32'h100,0, 1,0,0,            N,32'h100,0,2'b10, 2'b11,2'b00, 0, 0,0);
        vt[1]  = mk(I,0,0, I,0,0,       1,0,32'h12345678, I,0,0,2'b00,       2'b11,2'b00, W1, 0,32'h12345678);
        vt[2]  = mk(N,32'h200,1, N,32'h300,0, 1,0,0,      N,32'h200,1,2'b01, 2'b11,2'b00, 0, 0,0);
        vt[3]  = mk(I,0,0, I,0,0,       1,0,32'hAAAA0003, N,32'h300,0,2'b10, 2'b01,2'b00, W0, 32'hAAAA0003,0);
        vt[4]  = mk(I,0,0, I,0,0,       1,0,32'hAAAA0004, I,0,0,2'b00,       2'b11,2'b00, W1, 0,32'hAAAA0004);
        // Three slave wait states on a master 0 write while master 1 parks.
        vt[5]  = mk(N,32'h400,1, I,0,0, 1,0,0,            N,32'h400,1,2'b01, 2'b11,2'b00, 0, 0,0);
        vt[6]  = mk(I,0,0, N,32'h500,0, 0,0,0,            I,0,0,2'b00,       2'b10,2'b00, W0, 0,0);
        vt[7]  = mk(I,0,0, N,32'h500,0, 0,0,0,            I,0,0,2'b00,       2'b00,2'b00, W0, 0,0);
        vt[8]  = mk(I,0,0, N,32'h500,0, 0,0,0,            I,0,0,2'b00,       2'b00,2'b00, W0, 0,0);
        vt[9]  = mk(I,0,0, I,0,0,       1,0,32'hBBBB0009, N,32'h500,0,2'b10, 2'b01,2'b00, W0, 32'hBBBB0009,0);
        vt[10] = mk(I,0,0, I,0,0,       1,0,32'hBBBB000A, I,0,0,2'b00,       2'b11,2'b00, W1, 0,32'hBBBB000A);
        // Two-cycle error response to master 1; its retry on the second cycle is dropped.
        vt[11] = mk(I,0,0, N,32'h600,0, 1,0,0,            N,32'h600,0,2'b10, 2'b11,2'b00, 0, 0,0);
        vt[12] = mk(N,32'h700,1, I,0,0, 0,1,0,            I,0,0,2'b00,       2'b01,2'b10, W1, 0,0);
        vt[13] = mk(I,0,0, N,32'h800,0, 1,1,0,            N,32'h700,1,2'b01, 2'b10,2'b10, W1, 0,0);
        vt[14] = mk(I,0,0, I,0,0,       1,0,32'hCCCC000E, I,0,0,2'b00,       2'b11,2'b00, W0, 32'hCCCC000E,0);
        // Both masters streaming: eight alternating grants, then the last parked one drains.
        vt[15] = mk(N,32'h1000,0, N,32'h2000,0, 1,0,0,    N,32'h1000,0,2'b01, 2'b11,2'b00, 0, 0,0);
        for (int k = 16; k <= 22; k++) begin
            if (k % 2 == 0)
                vt[k] = mk(N,32'h1000,0, N,32'h2000,0, 1,0,0, N,32'h2000,0,2'b10, 2'b01,2'b00, W0, 0,0);
            else
                vt[k] = mk(N,32'h1000,0, N,32'h2000,0, 1,0,0, N,32'h1000,0,2'b01, 2'b10,2'b00, W1, 0,0);
        end
        vt[23] = mk(I,0,0, I,0,0,       1,0,0,            N,32'h1000,0,2'b01, 2'b10,2'b00, W1, 0,0);
        vt[24] = mk(I,0,0, I,0,0,       1,0,0,            I,0,0,2'b00,        2'b11,2'b00, W0, 0,0);

        m_hwdata[0] = W0;     m_hwdata[1] = W1;
        m_hwchk[0]  = 7'h11;  m_hwchk[1]  = 7'h22;
        m_hsize[0]  = 3'd2;   m_hsize[1]  = 3'd2;
        m_hpar[0]   = 6'h15;  m_hpar[1]   = 6'h2A;
        s_hrchk     = 7'h33;
        rst = 1'b1;
        drive(I,0,0, I,0,0, 1,0,32'h9999_0000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_htrans", 32'(s_htrans), 32'(HTRANS_IDLE));
        chk("rst_grant",  32'(s_grant), 0);
        chk("rst_hready", {30'd0, m_hready[1], m_hready[0]}, 3);
        chk("rst_hresp",  {30'd0, m_hresp[1], m_hresp[0]}, 0);
        chk("rst_hwdata", s_hwdata, 0);
        chk("rst_hrdata0", m_hrdata[0], 0);
        tick();
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            drive(vt[i].t0, vt[i].a0, vt[i].w0, vt[i].t1, vt[i].a1, vt[i].w1,
                  vt[i].rdy, vt[i].resp, vt[i].rdat);
            @(negedge clk);
            chk($sformatf("r%0d_htrans", i), 32'(s_htrans), 32'(vt[i].e_trans));
            chk($sformatf("r%0d_haddr", i),  s_haddr, vt[i].e_addr);
            chk($sformatf("r%0d_hwrite", i), 32'(s_hwrite), 32'(vt[i].e_wr));
            chk($sformatf("r%0d_grant", i),  32'(s_grant), 32'(vt[i].e_gnt));
            chk($sformatf("r%0d_hready", i), {30'd0, m_hready[1], m_hready[0]}, 32'(vt[i].e_rdy));
            chk($sformatf("r%0d_hresp", i),  {30'd0, m_hresp[1], m_hresp[0]}, 32'(vt[i].e_resp));
            chk($sformatf("r%0d_hwdata", i), s_hwdata, vt[i].e_wdata);
            chk($sformatf("r%0d_hrdata0", i), m_hrdata[0], vt[i].e_rd0);
            chk($sformatf("r%0d_hrdata1", i), m_hrdata[1], vt[i].e_rd1);
            tick();
        end

        // Reset pulse in the middle of a master 0 data phase.
        drive(N,32'h900,1, I,0,0, 1,0,0);
        @(negedge clk);
        chk("pre_rst_grant", 32'(s_grant), 1);
        tick();
        rst = 1'b1;
        drive(I,0,0, N,32'hA00,0, 1,0,32'hDDDD0001);
        @(negedge clk);
        chk("mid_rst_htrans", 32'(s_htrans), 0);
        chk("mid_rst_grant",  32'(s_grant), 0);
        chk("mid_rst_haddr",  s_haddr, 0);
        chk("mid_rst_hready", {30'd0, m_hready[1], m_hready[0]}, 3);
        chk("mid_rst_hwdata", s_hwdata, 0);
        chk("mid_rst_hrdata0", m_hrdata[0], 0);
        tick();
        rst = 1'b0;
        drive(I,0,0, I,0,0, 1,0,32'hDDDD0002);
        @(negedge clk);
        chk("post_rst_htrans", 32'(s_htrans), 0);
        chk("post_rst_hwdata", s_hwdata, 0);
        chk("post_rst_hrdata0", m_hrdata[0], 0);
        tick();
        drive(I,0,0, N,32'hA00,0, 1,0,0);
        @(negedge clk);
        chk("fresh_htrans", 32'(s_htrans), 32'(HTRANS_NONSEQ));
        chk("fresh_grant",  32'(s_grant), 2);
        chk("fresh_haddr",  s_haddr, 32'hA00);
        chk("fresh_hparity", 32'(s_hpar), 32'h2A);
        chk("fresh_hsize",  32'(s_hsize), 2);
        tick();
        drive(I,0,0, I,0,0, 1,0,32'h5555AAAA);
        @(negedge clk);
        chk("fresh_hrdata1", m_hrdata[1], 32'h5555AAAA);
        chk("fresh_hrchk1",  32'(m_hrchk[1]), 32'h33);
        chk("fresh_hrchk0",  32'(m_hrchk[0]), 0);
        chk("fresh_hwchk",   32'(s_hwchk), 32'h22);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
